// File: rtl/adc_spi_responder.sv
// Clock-domain model of an LTC2308-style SPI ADC: captures the config word,
// samples the selected channel at CONVST and returns the result MSB-first next frame.
module adc_spi_responder #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CFG_W       = 6,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADC_CS_N,
    input  logic              ADC_SCLK,
    input  logic              ADC_DIN,
    output logic              ADC_DOUT,
    input  logic [DATA_W-1:0] sample_in,
    output logic [2:0]        channel,
    output logic [CFG_W-1:0]  cfg,
    output logic              cfg_valid,
    output logic              frame_done,
    output logic              busy,
    input  logic              err_clr,
    output logic              conv_err
);

    localparam int unsigned TXW  = $clog2(DATA_W + 1);
    localparam int unsigned RXW  = $clog2(CFG_W + 1);
    localparam int unsigned CNTW = $clog2(CONV_CYCLES + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic              prev_csn_q, prev_csn_d;
    logic              prev_sclk_q, prev_sclk_d;
    logic              dout_q, dout_d;
    logic [2:0]        channel_q, channel_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              conv_err_q, conv_err_d;
    logic [DATA_W-1:0] result_q, result_d;
    // Shift registers omit the bit that is consumed directly on frame start / word completion.
    logic [DATA_W-2:0] tx_sr_q, tx_sr_d;
    logic [CFG_W-2:0]  cfg_sr_q, cfg_sr_d;
    logic [TXW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [RXW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [CNTW-1:0]   conv_cnt_q, conv_cnt_d;

    logic              csn_fall, csn_rise, sclk_rise, sclk_fall;
    logic [CFG_W-1:0]  cfg_word;

    assign csn_fall  = prev_csn_q & ~ADC_CS_N;
    assign csn_rise  = ~prev_csn_q & ADC_CS_N;
    assign sclk_rise = ~prev_sclk_q & ADC_SCLK;
    assign sclk_fall = prev_sclk_q & ~ADC_SCLK;
    assign cfg_word  = {cfg_sr_q, ADC_DIN};

    always_comb begin
        state_d      = state_q;
        prev_csn_d   = ADC_CS_N;
        prev_sclk_d  = ADC_SCLK;
        dout_d       = dout_q;
        channel_d    = channel_q;
        cfg_d        = cfg_q;
        cfg_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        conv_err_d   = conv_err_q;
        result_d     = result_q;
        tx_sr_d      = tx_sr_q;
        cfg_sr_d     = cfg_sr_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        conv_cnt_d   = conv_cnt_q;

        if (busy_q) begin
            if (conv_cnt_q == '0) busy_d = 1'b0;
            else                  conv_cnt_d = conv_cnt_q - 1'b1;
        end
        // Clear first so a coincident new error takes precedence.
        if (err_clr) conv_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (csn_fall) begin
                    state_d  = SHIFT;
                    tx_sr_d  = result_q[DATA_W-2:0];
                    dout_d   = result_q[DATA_W-1];
                    tx_cnt_d = TXW'(1);
                    rx_cnt_d = '0;
                    if (busy_q) conv_err_d = 1'b1;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    result_d     = sample_in;
                    busy_d       = 1'b1;
                    conv_cnt_d   = CNTW'(CONV_CYCLES - 1);
                    dout_d       = 1'b0;
                end else begin
                    if (sclk_rise && (rx_cnt_q < RXW'(CFG_W))) begin
                        cfg_sr_d = cfg_word[CFG_W-2:0];
                        rx_cnt_d = rx_cnt_q + 1'b1;
                        if (rx_cnt_q == RXW'(CFG_W - 1)) begin
                            cfg_d       = cfg_word;
                            channel_d   = {cfg_word[CFG_W-3], cfg_word[CFG_W-4], cfg_word[CFG_W-2]};
                            cfg_valid_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (tx_cnt_q < TXW'(DATA_W)) begin
                            dout_d   = tx_sr_q[DATA_W-2];
                            tx_sr_d  = tx_sr_q << 1;
                            tx_cnt_d = tx_cnt_q + 1'b1;
                        end else begin
                            dout_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_csn_q   <= 1'b1;
            prev_sclk_q  <= 1'b0;
            dout_q       <= 1'b0;
            channel_q    <= '0;
            cfg_q        <= '0;
            cfg_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            conv_err_q   <= 1'b0;
            result_q     <= '0;
            tx_sr_q      <= '0;
            cfg_sr_q     <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            conv_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_csn_q   <= prev_csn_d;
            prev_sclk_q  <= prev_sclk_d;
            dout_q       <= dout_d;
            channel_q    <= channel_d;
            cfg_q        <= cfg_d;
            cfg_valid_q  <= cfg_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            conv_err_q   <= conv_err_d;
            result_q     <= result_d;
            tx_sr_q      <= tx_sr_d;
            cfg_sr_q     <= cfg_sr_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            conv_cnt_q   <= conv_cnt_d;
        end
    end

    assign ADC_DOUT   = dout_q;
    assign channel    = channel_q;
    assign cfg        = cfg_q;
    assign cfg_valid  = cfg_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign conv_err   = conv_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized scoreboard bench for adc_spi_responder: stimulus pushes expected
// frame words and config captures; a negedge monitor pops and compares.
module tb_adc_spi_responder;

    localparam int DW   = 12;
    localparam int CW   = 6;
    localparam int CONV = 80;

    logic          clk = 1'b0;
    logic          reset, cs_n, sclk, din, err_clr;
    logic          dout, cfg_valid, frame_done, busy, conv_err;
    logic [DW-1:0] sample_in;
    logic [2:0]    channel;
    logic [CW-1:0] cfg;

    adc_spi_responder #(.DATA_W(DW), .CFG_W(CW), .CONV_CYCLES(CONV)) dut (
        .clk(clk), .reset(reset), .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_DIN(din),
        .ADC_DOUT(dout), .sample_in(sample_in), .channel(channel), .cfg(cfg),
        .cfg_valid(cfg_valid), .frame_done(frame_done), .busy(busy),
        .err_clr(err_clr), .conv_err(conv_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [DW-1:0] bits; int n; } word_t;
    typedef struct { logic [CW-1:0] cfgw; logic [2:0] ch; } cfg_t;
    word_t word_q[$];
    cfg_t  cfg_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DW-1:0] m_result;
    logic [CW-1:0] m_cfg;
    logic [2:0]    m_chan;
    logic          m_err;
    bit            have_rise;
    int unsigned   rise_det;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel number = 2*{S1,S0} + O/S
    function automatic logic [2:0] chan_of(input logic [CW-1:0] w);
        int s = (int'(w) >> 2) & 3;
        int o = (int'(w) >> 4) & 1;
        return 3'(2 * s + o);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_result  = '0;
        m_cfg     = '0;
        m_chan    = '0;
        m_err     = 1'b0;
        have_rise = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_channel"}, channel, 0);
        check({tag, "_cfg"}, cfg, 0);
        check({tag, "_cfg_valid"}, cfg_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_conv_err"}, conv_err, 0);
    endtask

    // Monitor: collect DOUT on every SCLK rise inside a frame; compare on frame_done / cfg_valid.
    logic [DW-1:0] cap;
    int            cap_n;
    logic          mprev_cs, mprev_sclk;

    always @(negedge clk) begin
        if (reset) begin
            cap = '0; cap_n = 0; mprev_cs = 1'b1; mprev_sclk = 1'b0;
        end else begin
            if (!cs_n && mprev_cs) begin
                cap = '0; cap_n = 0;
            end
            if (!cs_n && !mprev_cs && sclk && !mprev_sclk) begin
                cap = {cap[DW-2:0], dout};
                cap_n++;
            end
            if (frame_done) begin
                if (word_q.size() == 0) begin
                    check("frame_done_unexpected", 1, 0);
                end else begin
                    word_t w;
                    w = word_q.pop_front();
                    check("dout_bitcount", cap_n, w.n);
                    check("dout_word", cap, w.bits);
                end
            end
            if (cfg_valid) begin
                if (cfg_q.size() == 0) begin
                    check("cfg_valid_unexpected", 1, 0);
                end else begin
                    cfg_t c;
                    c = cfg_q.pop_front();
                    check("cfg_word", cfg, c.cfgw);
                    check("cfg_channel", channel, c.ch);
                end
            end
            mprev_cs   = cs_n;
            mprev_sclk = sclk;
        end
    end

    // One frame: nrise SCLK rises (the first coincides with CS_N fall when coinc),
    // optional err_clr at CS_N fall, optional reset abort after the last rise.
    task automatic do_frame(input logic [CW-1:0] cfgw, input int nrise, input bit coinc,
                            input bit clr, input bit abort, input bit meas,
                            input logic [DW-1:0] samp, input int half);
        int            start;
        int            n;
        int            idx;
        int            bc;
        int unsigned   fall_det;
        logic [DW-1:0] e;
        word_t         w;
        cfg_t          c;

        start = coinc ? 1 : 0;
        n     = nrise - start;
        e     = '0;
        for (int k = 0; k < n; k++) begin
            idx = DW - 1 - start - k;
            e   = {e[DW-2:0], m_result[idx]};
        end
        if (!abort) begin
            w.bits = e; w.n = n;
            word_q.push_back(w);
            if (n >= CW) begin
                c.cfgw = cfgw; c.ch = chan_of(cfgw);
                cfg_q.push_back(c);
            end
        end

        fall_det = cyc + 1;
        if (have_rise && (fall_det - rise_det) <= CONV) m_err = 1'b1;
        else if (clr)                                   m_err = 1'b0;

        sample_in = samp;
        err_clr   = clr;
        din       = 1'($urandom);
        sclk      = coinc;
        cs_n      = 1'b0;
        tick();
        err_clr = 1'b0;
        check("conv_err_at_fall", conv_err, m_err);
        if (coinc) begin
            repeat (half - 1) tick();
            sclk = 1'b0;
            repeat (half) tick();
        end else begin
            tick();
        end
        for (int j = 0; j < n; j++) begin
            din  = (j < CW) ? cfgw[CW-1-j] : 1'($urandom);
            sclk = 1'b1;
            repeat (half) tick();
            sclk = 1'b0;
            repeat (half) tick();
        end

        if (abort) begin
            reset = 1'b1;
            cs_n  = 1'b1;
            tick();
            check_reset_outputs("abort");
            tick();
            reset = 1'b0;
            model_reset();
            tick();
            return;
        end

        tick();
        cs_n      = 1'b1;
        rise_det  = cyc + 1;
        have_rise = 1'b1;
        tick();
        m_result = samp;
        if (n >= CW) begin
            m_cfg  = cfgw;
            m_chan = chan_of(cfgw);
        end
        check("frame_end_cfg", cfg, m_cfg);
        check("frame_end_channel", channel, m_chan);
        check("frame_end_dout_idle", dout, 0);
        if (meas) begin
            bc = 0;
            while (busy && bc < 200) begin
                bc++;
                tick();
            end
            check("busy_cycles", bc, CONV);
        end
    endtask

    task automatic idle_sclk(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (i % 2 == 0) sclk = ~sclk;
            tick();
            check("idle_dout", dout, 0);
        end
        sclk = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sweep_tab [8];
        logic [2:0] v;
        sweep_tab = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};

        reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; din = 1'b0; err_clr = 1'b0; sample_in = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Basic two-frame pipeline
        do_frame(6'b110010, 12, 0, 0, 0, 1, 12'hA5C, 2);
        check("first_channel", channel, 1);
        do_frame(6'($urandom), 12, 0, 0, 0, 1, 12'($urandom), 2);

        // Channel sweep over O/S,S1,S0
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            do_frame({1'b1, v, 2'b10}, 12, 0, 0, 0, 1, 12'($urandom), 2);
            check("sweep_channel", channel, sweep_tab[i]);
        end

        // Frame started while converting; this frame's rise restarts the conversion
        do_frame(6'($urandom), 12, 0, 0, 0, 0, 12'($urandom), 2);
        repeat (8) tick();
        do_frame(6'($urandom), 12, 0, 0, 0, 1, 12'($urandom), 2);
        check("conv_err_sticky", conv_err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 1'b0;
        check("conv_err_cleared", conv_err, 0);
        do_frame(6'($urandom), 12, 0, 0, 0, 1, 12'($urandom), 2);
        check("conv_err_after_clean_frame", conv_err, 0);

        // err_clr coincident with a new error: error wins
        do_frame(6'($urandom), 12, 0, 0, 0, 0, 12'($urandom), 2);
        repeat (4) tick();
        do_frame(6'($urandom), 12, 0, 1, 0, 1, 12'($urandom), 2);
        check("conv_err_beats_clr", conv_err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 1'b0;

        // Short frame keeps cfg/channel, still converts
        do_frame(6'($urandom), 3, 0, 0, 0, 1, 12'($urandom), 2);
        do_frame(6'($urandom), 12, 0, 0, 0, 1, 12'($urandom), 2);

        // Idle SCLK activity, then CS_N fall coincident with SCLK rise
        idle_sclk(16);
        do_frame(6'($urandom), 12, 1, 0, 0, 1, 12'($urandom), 2);
        do_frame(6'($urandom), 12, 0, 0, 0, 1, 12'($urandom), 2);

        // Reset mid-frame after 5 bits, then a fresh frame
        do_frame(6'($urandom), 5, 0, 0, 1, 0, 12'($urandom), 2);
        do_frame(6'($urandom), 12, 0, 0, 0, 1, 12'($urandom), 2);

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            int  nr;
            bit  co;
            co = ($urandom_range(0, 3) == 0);
            nr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 12;
            do_frame(6'($urandom), nr, co, 0, 0, 1, 12'($urandom), int'($urandom_range(2, 3)));
        end

        repeat (4) tick();
        check("word_queue_drained", word_q.size(), 0);
        check("cfg_queue_drained", cfg_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
